uart_rx_fifo: RTL

Parametrised buffered UART receiver: an oversampling 8N1 receive state machine feeding a configurable-depth byte FIFO, read through a single 32-bit status/data word. It replaces the fixed 32-entry receive buffer on the onboard bus. It adds framing-error detection, overflow detection, true full/empty reporting and a watermark interrupt for the flight controller.

---
 rtl/uart_rx_fifo.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: buffered 8N1 UART receiver.
//
// An oversampling receive FSM (IDLE/START/DATA/STOP/BREAK) samples the synchronized serial
// line at the centre of each bit and pushes good bytes into a 2**DEPTH entry byte FIFO.
// Framing errors and FIFO overflow raise sticky flags, and a registered IRQ fires on a
// watermark or either flag.
//
// Parameters:
//   CLK_DIV   clock cycles per UART bit (>= 8)
//   DEPTH     log2 of FIFO entries (2..8)
//   WATERMARK IRQ threshold in entries (1..2**DEPTH)
// Ports:
//   CLK      system clock
//   RESET    synchronous, active-high reset
//   RXD      asynchronous serial input, idle high
//   DATA_RD  registered status/data word:
//            [7:0] head byte, [16+DEPTH:16] count, [28] FULL, [29] EMPTY, [30] FERR, [31] OVF
//   DATA_WE  pop strobe, removes the head byte
//   CLR_WE   clears the sticky OVF and FERR flags
//   IRQ      registered interrupt request
module uart_rx_fifo #(
    parameter int unsigned CLK_DIV   = 434,
    parameter int unsigned DEPTH     = 5,
    parameter int unsigned WATERMARK = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        RXD,
    output logic [31:0] DATA_RD,
    input  logic        DATA_WE,
    input  logic        CLR_WE,
    output logic        IRQ
);

    localparam int unsigned NumEntries = 2 ** DEPTH;
    localparam int unsigned TimerW     = $clog2(CLK_DIV);

    localparam logic [TimerW-1:0] BitLoad   = TimerW'(CLK_DIV - 1);
    localparam logic [TimerW-1:0] HalfLoad  = TimerW'(CLK_DIV / 2 - 1);
    localparam logic [DEPTH:0]    FullCount = (DEPTH + 1)'(NumEntries);
    localparam logic [DEPTH:0]    WmCount   = (DEPTH + 1)'(WATERMARK);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } rx_state_e;

    // Synchronizer plus one extra stage for falling-edge detection
    logic rxd_meta_q, rxd_sync_q, rxd_prev_q;

    rx_state_e         state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              rx_push;
    logic              ferr_set;
    logic              timer_expired;

    logic [7:0]       mem_q [NumEntries];
    logic [DEPTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH:0]   count_q;
    logic             ovf_q, ferr_q;
    logic             empty, full;
    logic             pop_ok, push_ok, ovf_set;

    logic [31:0] status_word;
    logic [31:0] data_rd_q;
    logic        irq_q;

    assign timer_expired = (timer_q == '0);

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        rx_push   = 1'b0;
        ferr_set  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rxd_prev_q && !rxd_sync_q) begin
                    state_d = StStart;
                    timer_d = HalfLoad;
                end
            end
            StStart: begin
                if (timer_expired) begin
                    if (!rxd_sync_q) begin
                        state_d   = StData;
                        timer_d   = BitLoad;
                        bit_idx_d = 3'd0;
                    end else begin
                        // Line went back high before mid-bit: treat as a glitch
                        state_d = StIdle;
                    end
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            StData: begin
                if (timer_expired) begin
                    shift_d   = {rxd_sync_q, shift_q[7:1]};
                    timer_d   = BitLoad;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            StStop: begin
                if (timer_expired) begin
                    if (rxd_sync_q) begin
                        rx_push = 1'b1;
                        state_d = StIdle;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = StBreak;
                    end
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            StBreak: begin
                if (rxd_sync_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
            state_q    <= StIdle;
            timer_q    <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
        end else begin
            rxd_meta_q <= RXD;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
        end
    end

    // ------------------------------------------------------------------
    // FIFO and sticky flags
    // ------------------------------------------------------------------
    assign empty   = (count_q == '0);
    assign full    = (count_q == FullCount);
    assign pop_ok  = DATA_WE && !empty;
    // A pop in the same cycle frees a slot, so a push onto a full FIFO is still accepted
    assign push_ok = rx_push && (!full || pop_ok);
    assign ovf_set = rx_push && full && !pop_ok;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NumEntries; i++) begin
                mem_q[i] <= 8'd0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + DEPTH'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + DEPTH'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (DEPTH + 1)'(1);
                2'b01:   count_q <= count_q - (DEPTH + 1)'(1);
                default: count_q <= count_q;
            endcase
            // Set has priority over a coincident clear
            ovf_q  <= ovf_set || (ovf_q && !CLR_WE);
            ferr_q <= ferr_set || (ferr_q && !CLR_WE);
        end
    end

    // ------------------------------------------------------------------
    // Registered status word and interrupt
    // ------------------------------------------------------------------
    always_comb begin
        status_word                = '0;
        status_word[7:0]           = mem_q[rd_ptr_q];
        status_word[16 +: DEPTH+1] = count_q;
        status_word[28]            = full;
        status_word[29]            = empty;
        status_word[30]            = ferr_q;
        status_word[31]            = ovf_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            data_rd_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            data_rd_q <= status_word;
            irq_q     <= (count_q >= WmCount) || ovf_q || ferr_q;
        end
    end

    assign DATA_RD = data_rd_q;
    assign IRQ     = irq_q;

endmodule
